// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin arbitrated mux.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux4_rr_arbiter_pkg;

    localparam int QUANTUM_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Round-robin search starting at 'start'; result is {found, index}.
    // Walking offsets from the far end back to 0 lets the nearest hit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// Plain 4:1 combinational mux, index {s1,s0}.
// Latency: combinational.
// Backpressure: none.
module mux4to1 (
    output logic out,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic s0,
    input  logic s1
);

    // Select one of four data bits.
    always_comb begin
        out = a;
        case ({s1, s0})
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with per-owner quantum driving a registered 4:1 mux.
// Latency: req at edge k -> gnt/selects after k+1 -> dout/dout_vld after k+2.
// Backpressure: none; owners release on dropped req or expired quantum.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int QUANTUM = QUANTUM_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       dout,
    output logic       dout_vld,
    output logic [1:0] dout_id
);

    localparam logic [3:0] CNT_LAST = 4'(QUANTUM - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [3:0] cnt;
    logic [2:0] pick;
    logic       rel;
    logic       mux_out;

    // Next candidate: from ptr when idle, from owner+1 (owner last) when busy.
    always_comb begin
        rel  = (state == ST_BUSY) && (!req[owner] || (cnt == CNT_LAST));
        pick = rr_pick(req, (state == ST_BUSY) ? (owner + 2'd1) : ptr);
    end

    // Arbitration FSM; grant and selects are registered alongside the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            cnt      <= 4'd0;
            gnt      <= 4'd0;
            {s1, s0} <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick[2]) begin
                        state    <= ST_BUSY;
                        owner    <= pick[1:0];
                        cnt      <= 4'd0;
                        gnt      <= to_onehot(pick[1:0]);
                        {s1, s0} <= pick[1:0];
                    end
                end
                ST_BUSY: begin
                    if (rel) begin
                        // Re-arbitrate on the release edge so no dead cycle appears.
                        ptr <= owner + 2'd1;
                        cnt <= 4'd0;
                        if (pick[2]) begin
                            owner    <= pick[1:0];
                            gnt      <= to_onehot(pick[1:0]);
                            {s1, s0} <= pick[1:0];
                        end else begin
                            state    <= ST_IDLE;
                            gnt      <= 4'd0;
                            {s1, s0} <= 2'b00;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mux4to1 u_mux (
        .out (mux_out),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .s0  (s0),
        .s1  (s1)
    );

    // Output stage: capture the selected data together with who owned it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            dout_id  <= 2'd0;
        end else begin
            dout     <= mux_out;
            dout_vld <= (state == ST_BUSY);
            dout_id  <= owner;
        end
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter QUANTUM, default 4, meaning maximum consecutive grant cycles per owner; legal range 1..16.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  4  per-requester request, bit i = requester i.
REQ-005 a, b, c, d  input  1 each  data from requesters 0..3.
REQ-006 gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-007 s0, s1  output  1 each  mux selects, equal to owner index {s1,s0}.
REQ-008 dout  output  1  registered mux output.
REQ-009 dout_vld  output  1  dout holds granted data.
REQ-010 dout_id  output  2  index of requester whose data is on dout.

Function
REQ-011 FSM SHALL have two states: IDLE (no owner) and BUSY (owner valid).
REQ-012 IDLE->BUSY SHALL occur on the first edge where req != 0; owner = first set req bit searching ptr, ptr+1, ... mod 4.
REQ-013 In BUSY, cnt SHALL increment each cycle starting at 0 on grant.
REQ-014 Release SHALL occur when req[owner]==0 or cnt==QUANTUM-1.
REQ-015 On release, ptr SHALL become (owner+1) mod 4 and arbitration SHALL happen on the same edge with no dead cycle.
REQ-016 Re-arbitration search order SHALL be owner+1, owner+2, owner+3, then owner last.
REQ-017 Owner SHALL be regranted only if still requesting and no other req is set; cnt then restarts at 0.
REQ-018 If no req is set at release, the FSM SHALL go to IDLE and gnt SHALL become 0.
REQ-019 gnt SHALL be exactly one-hot in BUSY and zero in IDLE.
REQ-020 {s1,s0} SHALL equal owner in BUSY and 2'b00 in IDLE.
REQ-021 Latency: req sampled at edge k -> gnt/select valid after edge k+1 -> dout/dout_vld after edge k+2.
REQ-022 dout SHALL register the mux output; dout_vld SHALL register (state==BUSY); dout_id SHALL register owner.
REQ-023 Requests rising mid-grant SHALL NOT preempt the owner.
REQ-024 With QUANTUM=1, the grant SHALL rotate every cycle among active requesters.
REQ-025 cnt width SHALL be 4 bits; cnt SHALL never exceed QUANTUM-1.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, ptr 0, cnt 0, owner 0, gnt 0, s0/s1 0, dout 0, dout_vld 0, dout_id 0.
REQ-027 Reset asserted mid-grant SHALL drop gnt and dout_vld immediately, with no completion of the quantum.
REQ-028 After rst_n deasserts, the first arbitration SHALL search from requester 0.

Structure
REQ-029 A shared package/header SHALL hold the state encodings (IDLE=0, BUSY=1) and the QUANTUM default.
REQ-030 The block SHALL instantiate one mux4to1 (ports out, a, b, c, d, s0, s1) as its datapath sub-module.
REQ-031 Arbitration (ptr, owner, cnt, FSM) SHALL be in the parent.

Verification (QUANTUM=4 unless noted)
REQ-032 Reset, then req=4'b0100 held, c=1 -> gnt=4'b0100 after 1 edge; dout=1, dout_vld=1, dout_id=2 after 2 edges; grant held 4 cycles, then regranted to 2.
REQ-033 req=4'b1111 held -> grant order 0,1,2,3,0, each exactly 4 cycles, with no idle cycle between grants.
REQ-034 req=4'b0011; requester 0 drops req after 2 grant cycles -> gnt moves to 4'b0010 on the next edge; ptr=1.
REQ-035 QUANTUM=1, req=4'b1010 -> gnt alternates 4'b0010, 4'b1000 every cycle.
REQ-036 Mid-grant to requester 3, pulse rst_n low asynchronously between edges -> gnt, dout_vld and s1/s0 read 0 before the next edge; with req=4'b1000 held after release, requester 3 is regranted from search start 0.
REQ-037 Every cycle, a checker SHALL verify: gnt is one-hot or zero; {s1,s0} matches gnt; dout equals the data of the cycle-earlier owner.
